// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit carry-lookahead slice is
// reused once per nibble, LSB first, with the carry held in a register.

module cla4_slice (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = c_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s_o  = p ^ c[3:0];
  assign c_o  = c[4];
endmodule

module cla_nibble_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic [1:0]       dbg_state_o
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW    = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both 1. in_ready/out_valid are registered; once out_valid is raised
  // the result is held until out_ready is sampled high.

  state_t            state_q;
  logic [WIDTH-1:0]  opa_q;
  logic [WIDTH-1:0]  opb_q;
  logic [WIDTH-1:0]  sum_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic              cout_q;
  logic              ovf_q;
  logic              out_valid_q;
  logic              in_ready_q;

  logic [3:0]        slice_a;
  logic [3:0]        slice_b;
  logic [3:0]        slice_s;
  logic              slice_c;

  assign slice_a = opa_q[4*idx_q +: 4];
  assign slice_b = opb_q[4*idx_q +: 4];

  cla4_slice u_slice (
    .a_i (slice_a),
    .b_i (slice_b),
    .c_i (carry_q),
    .s_o (slice_s),
    .c_o (slice_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            opa_q      <= A;
            opb_q      <= Sub ? ~B : B;
            carry_q    <= Sub ? 1'b1 : Cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            // First edge after reset release raises in_ready here.
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= slice_s;
          carry_q             <= slice_c;
          if (idx_q == LAST_IDX) begin
            cout_q      <= slice_c;
            ovf_q       <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) & (slice_s[3] != opa_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign Sum         = sum_q;
  assign Cout        = cout_q;
  assign Ovf         = ovf_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Bench for cla_nibble_sequencer: directed cases, backpressure, mid-run reset
// and random operations against an integer-arithmetic reference.

module tb_cla_nibble_sequencer;
  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .Cin         (Cin),
    .Sub         (Sub),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Sum         (Sum),
    .Cout        (Cout),
    .Ovf         (Ovf),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    logic signed [WIDTH-1:0] sa16;
    logic signed [WIDTH-1:0] sb16;
    int ua, ub, sa, sb, r;
    ua = int'(a);
    ub = int'(b);
    sa16 = a;
    sb16 = b;
    sa = int'(sa16);
    sb = int'(sb16);
    if (sub) begin
      r  = ua - ub;
      co = (ua >= ub);
      ov = ((sa - sb) > 32767) || ((sa - sb) < -32768);
    end else begin
      r  = ua + ub + int'(cin);
      co = (r > 65535);
      ov = ((sa + sb + int'(cin)) > 32767) || ((sa + sb + int'(cin)) < -32768);
    end
    s = r[WIDTH-1:0];
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input int hold, input string tag);
    logic [WIDTH-1:0] es;
    logic             ec;
    logic             eo;
    int               cnt;
    model(a, b, cin, sub, es, ec, eo);
    cnt = 0;
    while (!in_ready && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_in_ready_idle"}, in_ready, 1);
    A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = WIDTH'($urandom); B = WIDTH'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
    check({tag, "_in_ready_run"}, in_ready, 0);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_latency"}, cnt, NIBBLES);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_cout"}, Cout, ec);
    check({tag, "_ovf"}, Ovf, eo);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      A = WIDTH'($urandom); B = WIDTH'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_sum"}, {Ovf, Cout, Sum}, {eo, ec, es});
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, out_valid, 0);
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_sum_kept"}, Sum, es);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {Ovf, Cout, Sum}, 0);
    #22;
    rst_n = 1'b1;
    check("rel_in_ready_pre", in_ready, 0);
    @(posedge clk); #1;
    check("rel_in_ready_post", in_ready, 1);

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "add_basic");
    do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, "ripple_cin");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "ripple_b1");
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "ovf_pos");
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "ovf_neg");
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, "sub_neg");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0, "sub_ovf");
    do_op(16'h1234, 16'h1234, 1'b1, 1'b1, 0, "sub_zero");
    do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 5, "backpressure");

    // reset in the middle of RUN
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_outputs", {Ovf, Cout, Sum}, 0);
    check("midrst_in_ready", in_ready, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready_back", in_ready, 1);
    for (int i = 0; i < NIBBLES + 2; i++) begin
      @(posedge clk); #1;
      check("midrst_no_valid", out_valid, 0);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 0, "post_rst");

    for (int i = 0; i < 25; i++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
Multi-cycle WIDTH-bit adder/subtractor built around one 4-bit carry-lookahead adder slice, which is instantiated internally. Each cycle it feeds one nibble of the operands through the slice, starting with the least significant nibble. The carry is held in a register between nibbles. Operands enter and results leave over valid/ready handshakes, so the block can be placed between a register file and a result bus that has backpressure.

Parameters:
WIDTH, 16, operand/result width in bits; multiple of 4, minimum 8
NIBBLES, WIDTH/4, derived localparam: number of RUN cycles per operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A, sampled on input handshake
B  input  WIDTH  operand B, sampled on input handshake
Cin  input  1  carry-in; ignored when Sub=1
Sub  input  1  1: compute A-B (B inverted, initial carry forced to 1)
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
Sum  output  WIDTH  result
Cout  output  1  carry out of bit WIDTH-1 (for Sub, 1 = no borrow)
Ovf  output  1  signed two's-complement overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0, all registers clear: state=IDLE, in_ready=0, out_valid=0, Sum=0, Cout=0, Ovf=0, internal idx=0, internal carry=0.
- in_ready is registered. It rises on the first rising edge after rst_n deasserts. After that it equals (state==IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE, in_valid & in_ready:
  - Capture opA=A and opB = Sub ? ~B : B.
  - Set carry = Sub ? 1 : Cin and idx=0.
  - Clear Sum to 0.
  - Next state RUN; in_ready drops to 0.
- IDLE without a handshake: hold all state.
- RUN, every cycle:
  - The slice adds opA[4*idx+:4] + opB[4*idx+:4] + carry.
  - At the clock edge, Sum[4*idx+:4] <= slice sum and carry <= slice carry-out.
  - If idx == NIBBLES-1: Cout <= slice carry-out; Ovf <= (opA[WIDTH-1]==opB[WIDTH-1]) & (slice sum[3] != opA[WIDTH-1]); out_valid <= 1; next state DONE.
  - Otherwise idx <= idx+1.
- RUN ignores in_valid and out_ready.
- DONE:
  - Sum, Cout, Ovf and out_valid stay stable until out_ready=1 is sampled.
  - On that edge: out_valid <= 0, next state IDLE, in_ready <= 1.
  - Sum, Cout and Ovf keep their values until the next accept.
- Latency: the accept edge is edge 0. out_valid is 1 after edge NIBBLES (4 edges for WIDTH=16).
- Minimum initiation interval: NIBBLES+2 cycles. There is no IDLE bypass.
- During RUN, Sum fills low nibble first, with upper nibbles still 0. Sum, Cout and Ovf are defined for the bench only while out_valid=1.
- Carry is chained between cycles by the register only. There is no combinational path from the inputs to the outputs.
- Reset asserted in any state immediately aborts the operation and gives the reset values above. The aborted operation is lost and produces no out_valid.
- A handshake on the same edge as reset deassertion is not accepted, because in_ready=0 on that edge.
- Arithmetic is mod 2^WIDTH. Cout and Ovf are computed as stated, with no saturation.

Test Plan:
1. WIDTH=16: A=0x1234, B=0x4321, Cin=0, Sub=0 -> Sum=0x5555, Cout=0, Ovf=0. out_valid rises exactly 4 edges after the accept. in_ready=0 from accept until DONE is handshaked.
2. Full carry ripple: A=0xFFFF, B=0x0000, Cin=1 -> Sum=0x0000, Cout=1, Ovf=0. Also A=0xFFFF, B=0x0001, Cin=0 -> the same result.
3. Overflow: A=0x7FFF, B=0x0001, Cin=0 -> Sum=0x8000, Cout=0, Ovf=1. Also A=0x8000, B=0x8000 -> Sum=0x0000, Cout=1, Ovf=1.
4. Subtract with Sub=1 and Cin=1 (Cin ignored):
   - A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0, Ovf=0.
   - A=0x8000, B=0x0001 -> Sum=0x7FFF, Cout=1, Ovf=1.
   - A=0x1234, B=0x1234 -> Sum=0x0000, Cout=1.
5. Backpressure: out_ready held at 0 for 5 cycles in DONE. out_valid and Sum stay stable. in_valid pulses are ignored and no new capture occurs. After out_ready=1, the next operation is accepted normally. Back-to-back operations are each checked against a reference model.
6. Reset mid-RUN: assert rst_n=0 after 2 nibbles of 0x1234+0x4321. Outputs go to 0 immediately and out_valid never rises. in_ready returns to 1 one edge after release. The next operation, 0x0001+0x0002, gives 0x0003.
